byte_bus_fetch_unit: RTL and testbench

- Memory-side responder for the CPU instruction/operand fetch interface.
- Accepts a fetch request (address) or a single-byte write from the core.
- Reads three consecutive bytes over an 8-bit synchronous memory bus and returns them as one 24-bit word.
- Sits between cpu_t and a byte-wide memory, so the core sees the 3-byte fetch port while the backing store stays NES-style 8-bit.

---
 rtl/byte_bus_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_byte_bus_fetch_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_bus_fetch_unit.sv
// byte_bus_fetch_unit
// ---------------------------------------------------------------------------
// Memory-side responder for the core's fetch port. It accepts either a
// 3-byte fetch or a single-byte write. A fetch runs three reads on a byte-wide
// synchronous bus and returns the bytes as one little-endian 24-bit word.
//
// Handshake: a request transfers on a rising clk_i edge when req_valid_i and
// req_ready_o are both 1. req_ready_o is high only in IDLE. Address and write
// data are captured at that edge. There is no response backpressure:
// resp_valid_o is a one-cycle pulse that the core must consume.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i                 1 = byte write, 0 = 3-byte fetch
//   req_addr_i, req_wdata_i  request address / write byte
//   resp_valid_o             one-cycle pulse, resp_data_o updated
//   resp_data_o              {mem[A+2], mem[A+1], mem[A]}
//   bus_addr_o, bus_rd_o, bus_wr_o, bus_wdata_o   byte-bus master side
//   bus_rdata_i              read data, valid the cycle after bus_rd_o
//
// Optional build macro BYTE_BUS_FETCH_REUSE_EN: keeps a tag of the last
// completed bus fetch. A fetch to the tagged address is answered from
// resp_data_o without touching the bus. Any write invalidates the tag.
// ---------------------------------------------------------------------------
module byte_bus_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_rd_o,
    output logic              bus_wr_o,
    output logic [7:0]        bus_wdata_o,
    input  logic [7:0]        bus_rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        RD1   = 3'd2,
        RD2   = 3'd3,
        DRAIN = 3'd4,
        RESP  = 3'd5,
        WR    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        byte0;
    logic [7:0]        byte1;

`ifdef BYTE_BUS_FETCH_REUSE_EN
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic              hit_q;     // RESP entered from a tag hit; pulse is one cycle later
`endif

    // All outputs are registered. Bus read data lags the address by one
    // cycle, so each byte is captured one state after its address is driven.
    // The last byte is captured in DRAIN straight into resp_data_o.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            bus_addr_o   <= '0;
            bus_rd_o     <= 1'b0;
            bus_wr_o     <= 1'b0;
            bus_wdata_o  <= '0;
            addr_q       <= '0;
            byte0        <= '0;
            byte1        <= '0;
`ifdef BYTE_BUS_FETCH_REUSE_EN
            tag_valid    <= 1'b0;
            tag_addr     <= '0;
            hit_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // ready rises on the first IDLE cycle after reset release
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        if (req_we_i) begin
                            bus_addr_o  <= req_addr_i;
                            bus_wdata_o <= req_wdata_i;
                            bus_wr_o    <= 1'b1;
                            state       <= WR;
`ifdef BYTE_BUS_FETCH_REUSE_EN
                            tag_valid   <= 1'b0;
`endif
                        end else begin
                            addr_q <= req_addr_i;
`ifdef BYTE_BUS_FETCH_REUSE_EN
                            if (tag_valid && (req_addr_i == tag_addr)) begin
                                hit_q <= 1'b1;
                                state <= RESP;
                            end else
`endif
                            begin
                                bus_addr_o <= req_addr_i;
                                bus_rd_o   <= 1'b1;
                                state      <= RD0;
                            end
                        end
                    end
                end
                RD0: begin
                    bus_addr_o <= addr_q + ONE;
                    state      <= RD1;
                end
                RD1: begin
                    byte0      <= bus_rdata_i;
                    bus_addr_o <= addr_q + TWO;
                    state      <= RD2;
                end
                RD2: begin
                    byte1    <= bus_rdata_i;
                    bus_rd_o <= 1'b0;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    resp_data_o  <= {bus_rdata_i, byte1, byte0};
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
`ifdef BYTE_BUS_FETCH_REUSE_EN
                    tag_valid    <= 1'b1;
                    tag_addr     <= addr_q;
`endif
                end
                RESP: begin
`ifdef BYTE_BUS_FETCH_REUSE_EN
                    if (hit_q) begin
                        hit_q        <= 1'b0;
                        resp_valid_o <= 1'b1;
                    end else
`endif
                    begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WR: begin
                    bus_wr_o    <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b0;
                    resp_valid_o <= 1'b0;
                    bus_rd_o     <= 1'b0;
                    bus_wr_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_bus_fetch_unit.sv
// tb_byte_bus_fetch_unit
// Bench for byte_bus_fetch_unit. A 64 KiB byte memory answers the bus. A
// separate reference image, updated only by the writes the bench issues,
// gives the expected fetch words.
module tb_byte_bus_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [23:0] resp_data;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          tag_valid    = 1'b0;
    logic [15:0] tag_addr     = '0;
    logic [23:0] last_resp    = '0;

    byte_bus_fetch_unit #(.ADDR_W(16), .DATA_W(24)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_data_o (resp_data),
        .bus_addr_o  (bus_addr),
        .bus_rd_o    (bus_rd),
        .bus_wr_o    (bus_wr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (bus_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    // synchronous byte memory: read data one cycle after the strobe
    always @(posedge clk) begin
        if (bus_rd) bus_rdata <= mem[bus_addr];
        if (bus_wr) mem[bus_addr] <= bus_wdata;
    end

    // reference word: three bytes from A upward, 16-bit wraparound
    function automatic logic [23:0] ref_word(input logic [15:0] a);
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {ref_mem[a2], ref_mem[a1], ref_mem[a]};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_ready: req_ready=%b required 1 within 20 cycles", req_ready);
        end
    endtask

    // Issue one fetch and check every cycle until the unit is ready again.
    task automatic do_fetch(input logic [15:0] a);
        logic [23:0] exp;
        logic [15:0] ak;
        bit          hit;
        exp = ref_word(a);
        hit = 1'b0;
`ifdef BYTE_BUS_FETCH_REUSE_EN
        hit = tag_valid && (tag_addr == a);
`endif
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);   // must be ignored after acceptance
        if (!hit) begin
            for (int k = 0; k < 6; k++) begin
                if (k > 0) @(negedge clk);
                ak = a + 16'(k);
                tests_run++;
                if (k < 3) begin
                    if (bus_rd !== 1'b1 || bus_addr !== ak || bus_wr !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL fetch_rd%0d: rd=%b wr=%b addr=%h rdy=%b rv=%b required rd=1 wr=0 addr=%h rdy=0 rv=0", k, bus_rd, bus_wr, bus_addr, req_ready, resp_valid, ak);
                    end
                end else if (k == 3) begin
                    if (bus_rd !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL fetch_drain: rd=%b rdy=%b rv=%b required 0 0 0", bus_rd, req_ready, resp_valid);
                    end
                end else if (k == 4) begin
                    if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0 || bus_rd !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL fetch_resp: rv=%b data=%h rdy=%b rd=%b required rv=1 data=%h rdy=0 rd=0", resp_valid, resp_data, req_ready, bus_rd, exp);
                    end
                end else begin
                    if (resp_valid !== 1'b0 || resp_data !== exp || req_ready !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL fetch_after: rv=%b data=%h rdy=%b required rv=0 data=%h rdy=1", resp_valid, resp_data, req_ready, exp);
                    end
                end
            end
            tag_valid = 1'b1;
            tag_addr  = a;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                tests_run++;
                if (bus_rd !== 1'b0 || bus_wr !== 1'b0 || resp_valid !== (k == 1) || (k == 1 && resp_data !== exp) || req_ready !== (k == 2)) begin
                    tests_failed++;
                    $display("FAIL hit_cycle%0d: rd=%b wr=%b rv=%b data=%h rdy=%b required rd=0 wr=0 rv=%b data=%h rdy=%b", k, bus_rd, bus_wr, resp_valid, resp_data, req_ready, (k == 1), exp, (k == 2));
                end
            end
        end
        last_resp = exp;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        tests_run++;
        if (bus_wr !== 1'b1 || bus_addr !== a || bus_wdata !== d || bus_rd !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_strobe: wr=%b addr=%h wd=%h rd=%b rv=%b rdy=%b required wr=1 addr=%h wd=%h rd=0 rv=0 rdy=0", bus_wr, bus_addr, bus_wdata, bus_rd, resp_valid, req_ready, a, d);
        end
        @(negedge clk);
        tests_run++;
        if (bus_wr !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== last_resp) begin
            tests_failed++;
            $display("FAIL write_done: wr=%b rv=%b rdy=%b data=%h required wr=0 rv=0 rdy=1 data=%h", bus_wr, resp_valid, req_ready, resp_data, last_resp);
        end
        ref_mem[a] = d;
        tag_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 24'h0 || bus_addr !== 16'h0 || bus_rd !== 1'b0 || bus_wr !== 1'b0 || bus_wdata !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_values: rdy=%b rv=%b data=%h addr=%h rd=%b wr=%b wd=%h required all 0", req_ready, resp_valid, resp_data, bus_addr, bus_rd, bus_wr, bus_wdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        tag_valid = 1'b0;
        last_resp = '0;
    endtask

    task automatic test_basic_fetch();
        mem[16'h0010] = 8'hA9; ref_mem[16'h0010] = 8'hA9;
        mem[16'h0011] = 8'h05; ref_mem[16'h0011] = 8'h05;
        mem[16'h0012] = 8'hEA; ref_mem[16'h0012] = 8'hEA;
        do_fetch(16'h0010);
        tests_run++;
        if (resp_data !== 24'hEA05A9) begin
            tests_failed++;
            $display("FAIL basic_word: data=%h required eа05a9", resp_data);
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'h33; ref_mem[16'h0001] = 8'h33;
        do_fetch(16'hFFFF);
    endtask

    task automatic test_write();
        do_write(16'h0200, 8'h7F);
        do_fetch(16'h0200);
        tests_run++;
        if (resp_data[7:0] !== 8'h7F) begin
            tests_failed++;
            $display("FAIL write_readback: low byte=%h required 7f", resp_data[7:0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom_range(16'h0400, 16'h0000));
            if ($urandom_range(2, 0) == 0) do_write(a, 8'($urandom));
            else do_fetch(a);
        end
    endtask

    // req_valid held high; request address scrambled while the unit is busy
    task automatic test_back_to_back();
        logic [15:0] exp_addr_q[$];
        logic [23:0] exp_q[$];
        logic [15:0] a_last;
        logic [15:0] ea;
        logic [23:0] ed;
        int          accepts  = 0;
        int          last_acc = -1;
        wait_ready();
        a_last    = tag_addr;
        req_we    = 1'b0;
        req_addr  = 16'($urandom);
        if (req_addr == a_last) req_addr = req_addr ^ 16'h0001;
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tests_run++;
            if ((bus_rd & bus_wr) !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_strobes: rd=%b wr=%b both high at cycle %0d", bus_rd, bus_wr, cyc);
            end
            if (bus_rd === 1'b1) begin
                ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
                tests_run++;
                if (bus_addr !== ea) begin
                    tests_failed++;
                    $display("FAIL b2b_bus_addr: addr=%h required %h at cycle %0d", bus_addr, ea, cyc);
                end
            end
            if (resp_valid === 1'b1) begin
                ed = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                tests_run++;
                if (resp_data !== ed) begin
                    tests_failed++;
                    $display("FAIL b2b_resp: data=%h required %h at cycle %0d", resp_data, ed, cyc);
                end
            end
            if (req_ready === 1'b1 && req_valid) begin
                if (accepts < 3) begin
                    if (last_acc >= 0) begin
                        tests_run++;
                        if (cyc - last_acc != 6) begin
                            tests_failed++;
                            $display("FAIL b2b_spacing: accept gap=%0d required 6", cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    accepts++;
                    a_last = req_addr;
                    exp_addr_q.push_back(a_last);
                    exp_addr_q.push_back(a_last + 16'd1);
                    exp_addr_q.push_back(a_last + 16'd2);
                    exp_q.push_back(ref_word(a_last));
                    tag_valid = 1'b1;
                    tag_addr  = a_last;
                    last_resp = ref_word(a_last);
                end else begin
                    req_valid = 1'b0;
                end
            end else if (req_valid) begin
                req_addr = 16'($urandom);
                if (req_addr == a_last) req_addr = req_addr ^ 16'h0001;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        tests_run++;
        if (accepts != 3 || exp_addr_q.size() != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_complete: accepts=%0d addr_left=%0d resp_left=%0d required 3 0 0", accepts, exp_addr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0010;
        @(posedge clk);
        @(negedge clk);          // RD0
        req_valid = 1'b0;
        @(negedge clk);          // RD1
        rstn = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 24'h0 || bus_addr !== 16'h0 || bus_rd !== 1'b0 || bus_wr !== 1'b0 || bus_wdata !== 8'h0) begin
            tests_failed++;
            $display("FAIL midreset_async: rdy=%b rv=%b data=%h addr=%h rd=%b wr=%b wd=%h required all 0", req_ready, resp_valid, resp_data, bus_addr, bus_rd, bus_wr, bus_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b0 || bus_rd !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_hold: rv=%b rd=%b required 0 0", resp_valid, bus_rd);
            end
        end
        rstn      = 1'b1;
        tag_valid = 1'b0;
        last_resp = '0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_release: rdy=%b rv=%b required 1 0", req_ready, resp_valid);
        end
        do_fetch(16'h0010);
    endtask

`ifdef BYTE_BUS_FETCH_REUSE_EN
    task automatic test_reuse();
        do_fetch(16'h0010);
        do_fetch(16'h0010);      // tag hit path
        do_write(16'h0300, 8'($urandom));
        do_fetch(16'h0010);      // tag cleared: full read sequence
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        bus_rdata = '0;
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_write();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef BYTE_BUS_FETCH_REUSE_EN
        test_reuse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
